// File: rtl/icache_fetch_pkg.sv
// Shared constants, FSM state type and address-split width helpers for the
// direct-mapped instruction cache.
package icache_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StDone
    } fetch_state_e;

    function automatic int unsigned off_bits(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w,
                                             input int unsigned lines,
                                             input int unsigned words);
        return addr_w - 2 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer: latches the missing line, walks its words over the
// req/ack handshake and tells the top when to write data and commit the line.
module icache_refill_fsm
    import icache_fetch_pkg::*;
#(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [ADDR_W-off_bits(WORDS)-3:0]    line_i,
    input  logic                                 flush_i,
    input  logic                                 mem_ack_i,
    output fetch_state_e                         state_o,
    output logic [ADDR_W-off_bits(WORDS)-3:0]    line_o,
    output logic [off_bits(WORDS)-1:0]           word_o,
    output logic                                 wr_en_o,
    output logic                                 fill_o,
    output logic                                 mem_req_o,
    output logic [ADDR_W-1:0]                    mem_addr_o
);

    localparam int unsigned OB = off_bits(WORDS);
    localparam int unsigned LW = ADDR_W - OB - 2;

    fetch_state_e  state_q, state_d;
    logic [OB-1:0] cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic          sticky_q, sticky_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            line_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        sticky_d  = sticky_q;
        mem_req_o = 1'b0;
        wr_en_o   = 1'b0;
        fill_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    line_d   = line_i;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = StRefill;
                end
            end
            StRefill: begin
                mem_req_o = 1'b1;
                if (flush_i) begin
                    sticky_d = 1'b1;
                end
                if (mem_ack_i) begin
                    wr_en_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // A flush seen anywhere in the burst means the line may be stale.
                fill_o   = ~(sticky_q | flush_i);
                sticky_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign state_o    = state_q;
    assign line_o     = line_q;
    assign word_o     = cnt_q;
    assign mem_addr_o = (state_q == StRefill) ? {line_q, cnt_q, 2'b00} : '0;

    req_held_until_ack: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (mem_req_o && !mem_ack_i) |=> (mem_req_o && $stable(mem_addr_o))
    );

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: combinational hit path in front
// of the fetch PC, line refill from backing memory on a miss.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int unsigned LINES  = 16,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              hit,
    output logic              stall_o,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned OB = off_bits(WORDS);
    localparam int unsigned IB = idx_bits(LINES);
    localparam int unsigned TW = tag_bits(ADDR_W, LINES, WORDS);
    localparam int unsigned LW = TW + IB;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    logic [LW-1:0]    pc_line;
    logic [IB-1:0]    pc_idx;
    logic [TW-1:0]    pc_tag;
    logic [OB-1:0]    pc_off;
    logic             unused_pc;

    fetch_state_e     state;
    logic [LW-1:0]    fill_line;
    logic [IB-1:0]    fill_idx;
    logic [TW-1:0]    fill_tag;
    logic [OB-1:0]    fill_word;
    logic             wr_en;
    logic             fill;
    logic             start;

    assign pc_line   = pc[ADDR_W-1:OB+2];
    assign pc_idx    = pc_line[IB-1:0];
    assign pc_tag    = pc_line[LW-1:IB];
    assign pc_off    = pc[OB+1:2];
    assign unused_pc = ^pc[1:0];

    assign hit     = (state == StIdle) & fetch_en & valid_q[pc_idx] &
                     (tag_q[pc_idx] == pc_tag);
    assign instr   = hit ? data_q[pc_idx][pc_off] : NOP_INSTR;
    assign stall_o = fetch_en & ~hit;
    assign start   = (state == StIdle) & fetch_en & ~hit & ~flush;

    assign fill_idx = fill_line[IB-1:0];
    assign fill_tag = fill_line[LW-1:IB];

    icache_refill_fsm #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_refill (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .line_i     (pc_line),
        .flush_i    (flush),
        .mem_ack_i  (mem_ack),
        .state_o    (state),
        .line_o     (fill_line),
        .word_o     (fill_word),
        .wr_en_o    (wr_en),
        .fill_o     (fill),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr)
    );

    // Flush beats a same-edge line commit so a fence.i is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[fill_idx][fill_word] <= mem_rdata;
        end
        if (fill) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Randomized bench for icache_fetch against a line-level cache model and a
// backing memory whose word at each address equals that address.
module tb_icache_fetch;

    localparam int unsigned LINES  = 16;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              flush;
    logic [31:0]       instr;
    logic              hit;
    logic              stall_o;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              resp_ack;
    logic              stray_ack;

    int n_checks = 0;
    int n_errors = 0;
    int gap      = 0;
    int wait_cnt = 0;

    bit          mvalid [LINES];
    logic [31:0] mline  [LINES];

    always #5 clk = ~clk;

    assign mem_ack = resp_ack | stray_ack;

    icache_fetch #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .instr     (instr),
        .hit       (hit),
        .stall_o   (stall_o),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a / (4 * WORDS);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(line_of(a) % LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[idx_of(a)] && (mline[idx_of(a)] == line_of(a));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    // Backing memory: waits `gap` request cycles, then acks for one cycle.
    initial begin
        resp_ack  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                resp_ack  = 1'b0;
                wait_cnt  = 0;
                mem_rdata = $urandom;
            end else if (wait_cnt >= gap) begin
                resp_ack  = 1'b1;
                mem_rdata = mem_addr & ~32'h3;
                wait_cnt  = 0;
            end else begin
                resp_ack  = 1'b0;
                mem_rdata = $urandom;
                wait_cnt++;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a);
        bit          exp_hit;
        bit          done;
        int          stalls;
        int          acks;
        logic [31:0] base;
        exp_hit  = model_hit(a);
        base     = line_of(a) * (4 * WORDS);
        done     = 1'b0;
        stalls   = 0;
        acks     = 0;
        pc       = a;
        fetch_en = 1'b1;
        flush    = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            check_eq("stall_is_not_hit", 32'(stall_o), 32'(!hit));
            if (hit) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req) begin
                    check_eq("mem_addr", mem_addr, base + 32'(4 * acks));
                    if (mem_ack) acks++;
                end
                @(posedge clk);
                #1;
            end
        end
        check_eq("fetch_done", 32'(done), 32'd1);
        check_eq("stall_cycles", 32'(stalls), exp_hit ? 32'd0 : 32'(WORDS * (gap + 1) + 2));
        check_eq("refill_acks", 32'(acks), exp_hit ? 32'd0 : 32'(WORDS));
        check_eq("instr", instr, a & ~32'h3);
        check_eq("req_on_hit", 32'(mem_req), 32'd0);
        mvalid[idx_of(a)] = 1'b1;
        mline[idx_of(a)]  = line_of(a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        int          acks;
        int          stalls;
        bit          done;
        bit          flushed;
        int          r;

        rst       = 1'b1;
        fetch_en  = 1'b1;
        flush     = 1'b0;
        stray_ack = 1'b0;
        pc        = 32'h10;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hit", 32'(hit), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_instr", instr, NOP);
        check_eq("rst_stall_en", 32'(stall_o), 32'd1);
        fetch_en = 1'b0;
        #1;
        check_eq("rst_stall_dis", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, same-line hits, conflict eviction.
        gap = 0;
        do_fetch(32'h10);
        do_fetch(32'h14);
        do_fetch(32'h1C);
        do_fetch(32'h110);
        do_fetch(32'h10);

        // Slow memory: three cycles per word.
        gap = 2;
        do_fetch(32'h20);
        do_fetch(32'h2C);
        gap = 0;

        // Flush on the second word of a refill.
        pc       = 32'h40;
        fetch_en = 1'b1;
        acks     = 0;
        stalls   = 0;
        done     = 1'b0;
        flushed  = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (hit) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req && mem_ack) acks++;
                @(posedge clk);
                #1;
                flush = (acks == 1) && !flushed;
                if (flush) flushed = 1'b1;
            end
        end
        flush = 1'b0;
        check_eq("flush_done", 32'(done), 32'd1);
        check_eq("flush_acks", 32'(acks), 32'(2 * WORDS));
        check_eq("flush_stalls", 32'(stalls), 32'(2 * (WORDS + 2)));
        check_eq("flush_instr", instr, 32'h40);
        @(posedge clk);
        #1;
        model_clear();
        mvalid[idx_of(32'h40)] = 1'b1;
        mline[idx_of(32'h40)]  = line_of(32'h40);
        do_fetch(32'h10);
        do_fetch(32'h20);

        // Reset after two acks of a refill.
        pc       = 32'h88;
        fetch_en = 1'b1;
        acks     = 0;
        for (int c = 0; c < 100 && acks < 2; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
            if (acks < 2) begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("pre_rst_acks", 32'(acks), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_req", 32'(mem_req), 32'd0);
        check_eq("async_rst_addr", mem_addr, 32'd0);
        check_eq("async_rst_hit", 32'(hit), 32'd0);
        check_eq("async_rst_instr", instr, NOP);
        check_eq("async_rst_stall", 32'(stall_o), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        fetch_en  = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        check_eq("stray_ack_req", 32'(mem_req), 32'd0);
        check_eq("idle_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        @(negedge clk);
        check_eq("stray_ack_ignored", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        model_clear();
        do_fetch(32'h88);
        do_fetch(32'h10);

        // Random mix of fetches, idle cycles and flushes.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
                ($urandom_range(0, 3) << 2);
            if (r == 0) begin
                pc       = a;
                fetch_en = 1'b1;
                flush    = 1'b1;
                @(negedge clk);
                check_eq("flush_lookup_hit", 32'(hit), 32'(model_hit(a)));
                check_eq("flush_lookup_stall", 32'(stall_o), 32'(!model_hit(a)));
                if (model_hit(a)) check_eq("flush_lookup_instr", instr, a);
                @(posedge clk);
                #1;
                flush    = 1'b0;
                fetch_en = 1'b0;
                model_clear();
                @(negedge clk);
                check_eq("flush_no_refill", 32'(mem_req), 32'd0);
                @(posedge clk);
                #1;
            end else if (r == 1) begin
                fetch_en = 1'b0;
                pc       = $urandom;
                @(negedge clk);
                check_eq("idle_hit", 32'(hit), 32'd0);
                check_eq("idle_stall", 32'(stall_o), 32'd0);
                check_eq("idle_req", 32'(mem_req), 32'd0);
                check_eq("idle_instr", instr, NOP);
                @(posedge clk);
                #1;
            end else begin
                gap = $urandom_range(0, 3);
                do_fetch(a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
